// File: rtl/digit_stream_reader_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | digit_stream_reader_pkg: shared state encoding and display constants    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package digit_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    localparam logic [5:0] EN_PLAY = 6'b11_0001;
    localparam logic [5:0] EN_OFF  = 6'b00_0000;

    // 1-based position as two BCD nibbles {tens, ones}; position never exceeds 16.
    function automatic logic [7:0] pos_to_bcd(input logic [3:0] addr);
        logic [4:0] pos;
        pos = {1'b0, addr} + 5'd1;
        if (pos >= 5'd10) begin
            return {4'd1, 4'(pos - 5'd10)};
        end
        return {4'd0, pos[3:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_stream_reader_dwell_timer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dwell_timer: counts enabled cycles, flags the last one of DWELL cycles  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module dwell_timer #(
    parameter int DWELL = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] c_last = CW'(DWELL - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    logic [CW-1:0] r_cnt;

    assign expire = en && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= expire ? '0 : r_cnt + c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/digit_stream_reader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | digit_stream_reader: snapshots packed BCD memory and plays it back      |
// | over a valid/ready stream with a per-digit display dwell. Rev 1.0       |
// +-------------------------------------------------------------------------+
module digit_stream_reader
    import digit_stream_reader_pkg::*;
#(
    parameter int DIGITS = 10,
    parameter int DWELL  = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    input  logic [4*DIGITS-1:0]   mem,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_addr,
    output logic [3:0]            out_digit,
    output logic                  busy,
    output logic                  done,
    output logic [5:0]            e,
    output logic [23:0]           d
);

    localparam logic [3:0] c_last_addr = 4'(DIGITS - 1);

    state_t                   r_state;
    logic [3:0]               r_addr;
    logic                     r_paused;
    logic                     r_done;
    logic [DIGITS-1:0][3:0]   r_snap;

    logic w_handshake;
    logic w_timer_en;
    logic w_expire;

    assign busy       = (r_state != ST_IDLE);
    assign out_valid  = (r_state == ST_OFFER) && !r_paused;
    assign out_addr   = r_addr;
    assign out_digit  = r_snap[r_addr];
    assign done       = r_done;
    assign w_handshake = out_valid && out_ready;
    assign w_timer_en  = (r_state == ST_DWELL) && !r_paused;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_handshake),
        .en     (w_timer_en),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= 4'd0;
            r_paused <= 1'b0;
            r_done   <= 1'b0;
            r_snap   <= '0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                // Start overrides pause and any pending final expiry.
                r_state  <= ST_OFFER;
                r_addr   <= 4'd0;
                r_paused <= 1'b0;
                r_snap   <= mem;
            end else begin
                if (pause && busy) begin
                    r_paused <= !r_paused;
                end
                case (r_state)
                    ST_OFFER: begin
                        if (w_handshake) begin
                            r_state <= ST_DWELL;
                        end
                    end
                    ST_DWELL: begin
                        if (w_expire) begin
                            if (r_addr == c_last_addr) begin
                                r_state  <= ST_IDLE;
                                r_done   <= 1'b1;
                                r_paused <= 1'b0;
                            end else begin
                                r_state <= ST_OFFER;
                                r_addr  <= r_addr + 4'd1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        e = EN_OFF;
        d = 24'h0;
        if (busy) begin
            e         = EN_PLAY;
            d[23:16]  = pos_to_bcd(r_addr);
            d[3:0]    = out_digit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_stream_reader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_digit_stream_reader: randomized and directed checks against a        |
// | behavioural playback model. Rev 1.0                                     |
// +-------------------------------------------------------------------------+
module tb_digit_stream_reader;

    localparam int DIGITS = 10;
    localparam int DWELL  = 4;

    logic        clk = 1'b0;
    logic        reset, start, pause, out_ready;
    logic [39:0] mem;
    logic        out_valid, busy, done;
    logic [3:0]  out_addr, out_digit;
    logic [5:0]  e;
    logic [23:0] d;

    int checks = 0;
    int errors = 0;

    // Behavioural model: playing flag, offering flag, position, remaining dwell.
    bit m_play, m_offer, m_paused, m_done;
    int m_pos, m_left;
    int m_snap[DIGITS];

    always #5 clk = ~clk;

    digit_stream_reader #(
        .DIGITS (DIGITS),
        .DWELL  (DWELL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .mem       (mem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_digit (out_digit),
        .busy      (busy),
        .done      (done),
        .e         (e),
        .d         (d)
    );

    function automatic logic [28:0] pack(input logic v, input logic b, input logic dn,
                                         input logic [5:0] en, input logic [3:0] a,
                                         input logic [3:0] dg, input logic [3:0] h5,
                                         input logic [3:0] h4, input logic [3:0] h0);
        return {v, b, dn, en, v ? a : 4'h0, v ? dg : 4'h0,
                b ? h5 : 4'h0, b ? h4 : 4'h0, b ? h0 : 4'h0};
    endfunction

    function automatic logic [28:0] exp_vec();
        logic [3:0] a;
        logic [3:0] dg;
        a  = 4'(m_pos);
        dg = 4'(m_snap[m_pos]);
        return pack(m_play && m_offer && !m_paused, m_play, m_done,
                    m_play ? 6'b110001 : 6'b000000, a, dg,
                    4'((m_pos + 1) / 10), 4'((m_pos + 1) % 10), dg);
    endfunction

    function automatic logic [28:0] obs_vec();
        return pack(out_valid, busy, done, e, out_addr, out_digit, d[23:20], d[19:16], d[3:0]);
    endfunction

    task automatic model_update(input logic rs, input logic s, input logic p,
                                input logic r, input logic [39:0] mv);
        bit was_paused;
        if (rs) begin
            m_play = 0; m_offer = 0; m_paused = 0; m_done = 0; m_pos = 0;
            for (int i = 0; i < DIGITS; i++) m_snap[i] = 0;
            return;
        end
        m_done = 0;
        if (s) begin
            m_play = 1; m_offer = 1; m_pos = 0; m_paused = 0;
            for (int i = 0; i < DIGITS; i++) m_snap[i] = int'(mv[4*i +: 4]);
            return;
        end
        if (!m_play) return;
        was_paused = m_paused;
        if (p) m_paused = !m_paused;
        if (was_paused) return;
        if (m_offer) begin
            if (r) begin
                m_offer = 0;
                m_left  = DWELL;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_pos == DIGITS - 1) begin
                    m_play = 0; m_done = 1; m_paused = 0;
                end else begin
                    m_pos++;
                    m_offer = 1;
                end
            end
        end
    endtask

    // One clock: inputs already driven at negedge, model advances with the DUT.
    task automatic step();
        @(posedge clk);
        model_update(reset, start, pause, out_ready, mem);
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic advance_to(input int addr, input string tag);
        int n;
        n = 0;
        while (!(out_valid && out_addr == 4'(addr)) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL %s timeout waiting for addr %0d (got valid=%b addr=%0d)", tag, addr, out_valid, out_addr);
        end
        checks++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pause = 1'b0; out_ready = 1'b0; mem = '0;
        step();
        step();
        if ({out_valid, busy, done, e} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b required=0", {out_valid, busy, done, e});
        end
        checks++;
        reset = 1'b0;
        step();
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle got=%h required=%h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_playback();
        int q_addr[$];
        int q_digit[$];
        int q_cyc[$];
        int n_done;
        n_done = 0;
        mem = 40'h9876543210; out_ready = 1'b1; start = 1'b1;
        step();
        for (int i = 0; i < 60; i++) begin
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL playback cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (out_valid && out_ready) begin
                q_addr.push_back(int'(out_addr));
                q_digit.push_back(int'(out_digit));
                q_cyc.push_back(i);
            end
            if (done === 1'b1) n_done++;
            step();
        end
        if (q_addr.size() != DIGITS) begin
            errors++;
            $display("FAIL playback_count got=%0d required=%0d", q_addr.size(), DIGITS);
        end
        checks++;
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_addr[i] != i || q_digit[i] != i) begin
                errors++;
                $display("FAIL playback_seq idx=%0d got addr=%0d digit=%0d required %0d", i, q_addr[i], q_digit[i], i);
            end
            checks++;
            if (i > 0 && q_cyc[i] - q_cyc[i-1] != DWELL + 1) begin
                errors++;
                $display("FAIL playback_spacing idx=%0d got=%0d required=%0d", i, q_cyc[i] - q_cyc[i-1], DWELL + 1);
            end
        end
        if (n_done != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL playback_done got done_count=%0d busy=%b required 1 and 0", n_done, busy);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        mem = 40'h9876543210; out_ready = 1'b1; start = 1'b1;
        step();
        advance_to(3, "backpressure");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if ({out_valid, out_addr, out_digit} !== {1'b1, 4'd3, 4'd3}) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d got=%h required=133", i, {out_valid, out_addr, out_digit});
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL backpressure_model got=%h required=%h", obs_vec(), exp_vec());
            end
            checks++;
        end
        out_ready = 1'b1;
        step();
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_accept got valid=%b busy=%b required 0 1", out_valid, busy);
        end
        checks++;
    endtask

    task automatic test_pause();
        int n;
        mem = 40'h9876543210; out_ready = 1'b1; start = 1'b1;
        step();
        advance_to(5, "pause");
        step();
        pause = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL pause_hold cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            step();
        end
        pause = 1'b1;
        step();
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n != DWELL - 1 || out_addr !== 4'd6) begin
            errors++;
            $display("FAIL pause_resume got cycles=%0d addr=%0d required %0d and 6", n, out_addr, DWELL - 1);
        end
        checks++;
    endtask

    task automatic test_snapshot_restart();
        mem = {8'($urandom), 32'($urandom)}; out_ready = 1'b1; start = 1'b1;
        step();
        for (int i = 0; i < 12; i++) step();
        mem = 40'h1111111111;
        for (int i = 0; i < 15; i++) begin
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL snapshot cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            step();
        end
        start = 1'b1; pause = 1'b1;
        step();
        if ({out_valid, out_addr, out_digit} !== {1'b1, 4'd0, 4'd1}) begin
            errors++;
            $display("FAIL restart_with_pause got=%h required=101", {out_valid, out_addr, out_digit});
        end
        checks++;
        while (m_play) begin
            step();
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL restart_run got=%h required=%h", obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        int n_done;
        n_done = 0;
        mem = 40'h9876543210; out_ready = 1'b1; start = 1'b1;
        step();
        advance_to(7, "reset_mid");
        reset = 1'b1;
        step();
        reset = 1'b0;
        if ({out_valid, busy, e} !== 8'b0) begin
            errors++;
            $display("FAIL reset_mid got=%b required=0", {out_valid, busy, e});
        end
        checks++;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) n_done++;
            step();
        end
        if (n_done != 0) begin
            errors++;
            $display("FAIL reset_mid_done got=%0d required=0", n_done);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            start     = m_play ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 4) == 0);
            pause     = ($urandom_range(0, 14) == 0);
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) mem = {8'($urandom), 32'($urandom)};
            step();
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_playback();
        test_backpressure();
        test_pause();
        test_snapshot_restart();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
